ysyx_22040237_mdu: RTL

Iterative multiply/divide unit for the NPC execute stage, implementing the RV64M operation set over a parametrised data width. It sits beside the combinational ALU: the decoder steers M-extension instructions here, and the stage stalls on a valid/ready handshake until the result returns. Multiplication and division each retire one bit per cycle from a shared shift datapath; division-by-zero and signed overflow short-circuit to a one-cycle result.

---
 rtl/ysyx_22040237_mdu.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ysyx_22040237_mdu.sv
// ysyx_22040237_mdu: iterative RV64M multiply/divide unit, one result bit per cycle.
// Define YSYX_22040237_MDU_WORD_EN (XLEN=64 only) to enable the W-suffixed ops.
module ysyx_22040237_mdu #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            out_err
);
`ifdef YSYX_22040237_MDU_WORD_EN
    localparam bit WEN = XLEN == 64;
`else
    localparam bit WEN = 1'b0;
`endif
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

    state_e            state_q;
    logic [2*XLEN-1:0] a_q, acc_q, acc_d, prod;
    logic [XLEN-1:0]   b_q, b_d, quo, rem, raw, x1, x2, m1, m2, spec;
    logic [XLEN:0]     r_sh, diff;
    logic [CW-1:0]     cnt_q;
    logic [3:0]        op_q;
    logic              nq_q, nr_q, w_q, ww, dv, sg1, sg2, n1, n2, legal, dz, ovf;

    function automatic logic [XLEN-1:0] fmt(input logic w_i, input logic [XLEN-1:0] v);
        return w_i ? XLEN'($signed(v[31:0])) : v;
    endfunction

    assign in_ready = state_q == IDLE;

    // Request decode: operands are reduced to magnitudes plus sign flags.
    always_comb begin
        ww    = WEN && op[3];
        dv    = op[2];
        legal = !op[3] || (WEN && (op == 4'h8 || op[2]));
        sg1   = dv ? !op[0] : (op[1:0] == 2'd1 || op[1:0] == 2'd2);
        sg2   = dv ? !op[0] : op[1:0] == 2'd1;
        x1    = ww ? (sg1 ? XLEN'($signed(src1[31:0])) : XLEN'(src1[31:0])) : src1;
        x2    = ww ? (sg2 ? XLEN'($signed(src2[31:0])) : XLEN'(src2[31:0])) : src2;
        n1    = sg1 && x1[XLEN-1];
        n2    = sg2 && x2[XLEN-1];
        m1    = n1 ? -x1 : x1;
        m2    = n2 ? -x2 : x2;
        dz    = dv && x2 == '0;
        ovf   = dv && n1 && x2 == '1 && m1 == (ww ? XLEN'(1) << 31 : XLEN'(1) << (XLEN-1));
        spec  = dz ? (op[1] ? x1 : '1) : (op[1] ? '0 : x1);
    end

    // One iteration of the shared shift datapath plus final sign fix-up.
    always_comb begin
        r_sh  = {acc_q[XLEN-1:0], b_q[XLEN-1]};
        diff  = r_sh - {1'b0, a_q[XLEN-1:0]};
        acc_d = op_q[2] ? {XLEN'(0), diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0]}
                        : acc_q + (b_q[0] ? a_q : '0);
        b_d   = op_q[2] ? {b_q[XLEN-2:0], ~diff[XLEN]} : b_q >> 1;
        prod  = nq_q ? -acc_d : acc_d;
        quo   = nq_q ? -b_d : b_d;
        rem   = nr_q ? -acc_d[XLEN-1:0] : acc_d[XLEN-1:0];
        raw   = op_q[2] ? (op_q[1] ? rem : quo)
                        : ((op_q[3] || op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            out_err   <= 1'b0;
            cnt_q     <= '0;
            op_q      <= '0;
            nq_q      <= 1'b0;
            nr_q      <= 1'b0;
            w_q       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
        end else if (flush) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    op_q  <= op;
                    w_q   <= ww;
                    nq_q  <= n1 ^ n2;
                    nr_q  <= n1;
                    a_q   <= {XLEN'(0), dv ? m2 : m1};
                    b_q   <= dv ? (ww ? m1 << (XLEN-32) : m1) : m2;
                    acc_q <= '0;
                    cnt_q <= '0;
                    if (!legal || dz || ovf) begin
                        state_q <= DONE;
                        result  <= legal ? fmt(ww, spec) : '0;
                        out_err <= !legal;
                    end else begin
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    b_q   <= b_d;
                    a_q   <= op_q[2] ? a_q : a_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == (w_q ? CW'(31) : CW'(XLEN-1))) begin
                        state_q <= DONE;
                        result  <= fmt(w_q, raw);
                        out_err <= 1'b0;
                    end
                end
                DONE: if (out_valid && out_ready) begin
                    state_q   <= IDLE;
                    out_valid <= 1'b0;
                end else begin
                    out_valid <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
